// File: rtl/video_pkg.sv
// Video constants and the pixel record. The pixel generator, this write queue
// and the VGA adapter all share this package.
package video_pkg;

    localparam int X_MAX     = 160;
    localparam int Y_MAX     = 120;
    localparam int FB_ADDR_W = 15;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] color;
    } pixel_t;

    // Linear framebuffer address y*160 + x, computed as shift-and-add.
    // The largest value, 19199, fits in FB_ADDR_W bits.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] px, input logic [6:0] py);
        return (FB_ADDR_W'(py) << 7) + (FB_ADDR_W'(py) << 5) + FB_ADDR_W'(px);
    endfunction

endpackage

// File: rtl/pixel_write_queue_if.sv
// Valid/ready write port from the pixel write queue toward the video memory.
interface pixel_write_queue_if #(
    parameter int ADDR_W = video_pkg::FB_ADDR_W
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pixel_write_queue_fifo.sv
// Synchronous FIFO of pixel_t. The read data comes from the head entry with no
// read latency. Occupancy is kept in its own counter beside the wrapping pointers.
module pixel_fifo
    import video_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  pixel_t           din,
    output pixel_t           dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    pixel_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When the FIFO is full, a pop in the same cycle frees the slot that this push reuses.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is left out of reset on purpose. The count and pointers
    // decide which entries are valid, so a reset on the array would only add
    // fanout and would stop it from mapping onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Each flop
    // then samples the value from before the edge, and the result does not
    // depend on the order in which blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_queue.sv
// Filters off-screen pixels and queues the rest. Each queued pixel becomes a
// registered linear framebuffer write on a valid/ready port.
module pixel_write_queue #(
    parameter int X_MAX  = video_pkg::X_MAX,
    parameter int Y_MAX  = video_pkg::Y_MAX,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = video_pkg::FB_ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       plot,
    input  logic [7:0]                 x,
    input  logic [6:0]                 y,
    input  logic [2:0]                 color,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 oob_count,
    pixel_write_queue_if.master        wr,
    output logic                       idle
);
    import video_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pixel_t            pix_in;
    pixel_t            head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic              in_range;
    logic              drain;
    logic              pop;
    logic              push;

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        data_q;

    assign pix_in = pixel_t'{x: x, y: y, color: color};

    // NOTE: every signal assigned in this block gets a value on every path,
    // starting with these defaults. This keeps the block purely combinational
    // and prevents latch inference.
    always_comb begin
        in_range = 1'b0;
        drain    = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;

        in_range = (int'(x) < X_MAX) && (int'(y) < Y_MAX);
        drain    = valid_q && wr.wr_ready;
        pop      = !fifo_empty && (!valid_q || drain);
        push     = plot && in_range && (!fifo_full || pop);
    end

    pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pix_in),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Status: overflow is sticky until reset, and the off-screen count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            oob_count <= '0;
        end else begin
            if (plot && in_range && !push) begin
                overflow <= 1'b1;
            end
            if (plot && !in_range && (oob_count != 8'hFF)) begin
                oob_count <= oob_count + 8'd1;
            end
        end
    end

    // Output register: loaded from the FIFO head only. It holds while the memory stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (pop) begin
            valid_q <= 1'b1;
            addr_q  <= ADDR_W'(fb_addr(head.x, head.y));
            data_q  <= head.color;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign wr.wr_valid = valid_q;
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = data_q;

    assign full = fifo_full;
    assign idle = (fifo_count == '0) && !valid_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Scoreboard bench for pixel_write_queue. A count-level reference model predicts
// status and accepted pixels, and a negedge monitor checks every completed write.
module tb_pixel_write_queue;
    import video_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       plot = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] color = '0;
    logic       full;
    logic       overflow;
    logic [7:0] oob_count;
    logic       idle;

    pixel_write_queue_if #(.ADDR_W(15)) wif ();

    pixel_write_queue #(
        .X_MAX  (160),
        .Y_MAX  (120),
        .DEPTH  (DEPTH),
        .ADDR_W (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .plot      (plot),
        .x         (x),
        .y         (y),
        .color     (color),
        .full      (full),
        .overflow  (overflow),
        .oob_count (oob_count),
        .wr        (wif.master),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   writes = 0;

    // Reference model: total pixels held in the queue, plus whether a write is presented.
    int   m_f = 0;
    bit   m_v = 1'b0;
    bit   m_ovf = 1'b0;
    int   m_oob = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Checks the state left by the previous edge, drives one cycle, advances the model.
    task automatic step(input bit p, input int px, input int py, input int pc,
                        input bit r, input bit rst);
        int  vx;
        int  vy;
        bit  inr;
        bit  pop_m;
        bit  push_m;
        exp_t e;

        check("full", full, (m_f == DEPTH));
        check("overflow", overflow, m_ovf);
        check("oob_count", oob_count, m_oob);
        check("idle", idle, (m_f == 0) && !m_v);
        check("wr_valid", wif.wr_valid, m_v);

        reset        = rst;
        plot         = p;
        x            = px[7:0];
        y            = py[6:0];
        color        = pc[2:0];
        wif.wr_ready = r;

        if (rst) begin
            m_f   = 0;
            m_v   = 1'b0;
            m_ovf = 1'b0;
            m_oob = 0;
            sb.delete();
        end else begin
            vx  = px & 255;
            vy  = py & 127;
            inr = p && (vx < 160) && (vy < 120);
            if (p && !inr && m_oob < 255) m_oob++;
            // A pixel leaves the queue storage when the output slot is free or is being taken.
            pop_m  = (m_f > 0) && (!m_v || r);
            push_m = inr && ((m_f < DEPTH) || pop_m);
            if (inr && !push_m) m_ovf = 1'b1;
            if (push_m) begin
                e.addr = vy * 160 + vx;
                e.data = pc & 7;
                sb.push_back(e);
            end
            if (pop_m) m_v = 1'b1;
            else if (m_v && r) m_v = 1'b0;
            m_f = m_f + int'(push_m) - int'(pop_m);
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input bit r);
        step(1'b0, 0, 0, 0, r, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH; i++) idle_step(1'b1);
        check("drain_sb_empty", sb.size(), 0);
        check("drain_idle", idle, 1);
    endtask

    // Monitor: each completed handshake pops one expected write, and a stalled write must hold.
    bit          prev_stall = 1'b0;
    logic [14:0] prev_addr;
    logic [2:0]  prev_data;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", wif.wr_valid, 1);
                check("stall_addr_hold", wif.wr_addr, prev_addr);
                check("stall_data_hold", wif.wr_data, prev_data);
            end
            if (wif.wr_valid === 1'b1 && wif.wr_ready === 1'b1) begin
                writes++;
                if (sb.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", wif.wr_addr, e.addr);
                    check("wr_data", wif.wr_data, e.data);
                end
            end
            prev_stall = (wif.wr_valid === 1'b1) && (wif.wr_ready !== 1'b1);
            prev_addr  = wif.wr_addr;
            prev_data  = wif.wr_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int bias;

        wif.wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_addr", wif.wr_addr, 0);
        check("rst_wr_data", wif.wr_data, 0);
        check("rst_idle", idle, 1);

        // Single pixel: written two cycles after the plot, then the queue goes idle.
        step(1'b1, 5, 3, 5, 1'b1, 1'b0);
        idle_step(1'b1);
        check("lat_valid", wif.wr_valid, 1);
        check("lat_addr", wif.wr_addr, 485);
        check("lat_data", wif.wr_data, 5);
        idle_step(1'b1);
        check("lat_idle", idle, 1);

        // Boundaries.
        step(1'b1, 159, 119, 7, 1'b1, 1'b0);
        step(1'b1, 160, 0, 1, 1'b1, 1'b0);
        check("corner_addr", wif.wr_addr, 19199);
        step(1'b1, 0, 120, 2, 1'b1, 1'b0);
        drain();
        check("oob_two", oob_count, 2);
        for (int i = 0; i < 300; i++) step(1'b1, 160 + (i % 96), i % 128, i % 8, 1'b1, 1'b0);
        check("oob_saturate", oob_count, 255);

        // Backpressure: the 17th plot fills the queue and the 18th is lost.
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            step(1'b1, i * 9, 7 + i, i % 8, 1'b0, 1'b0);
            if (i == 16) check("bp_full_17", full, 1);
            if (i == 16) check("bp_no_ovf_17", overflow, 0);
        end
        check("bp_ovf_18", overflow, 1);
        w0 = writes;
        for (int i = 0; i < 17; i++) idle_step(1'b1);
        check("bp_17_writes", writes - w0, 17);
        idle_step(1'b1);
        check("bp_no_extra", writes - w0, 17);
        check("bp_idle", idle, 1);

        // Full with a pop every cycle: each push is accepted.
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, i, 50, i % 8, 1'b0, 1'b0);
        check("fp_full", full, 1);
        for (int i = 0; i < 40; i++) step(1'b1, 100 + i, 60, (i + 3) % 8, 1'b1, 1'b0);
        check("fp_still_full", full, 1);
        check("fp_no_ovf", overflow, 0);
        drain();

        // Reset mid-burst discards everything in flight.
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 20 + i, 30, i % 8, 1'b0, 1'b0);
        step(1'b1, 40, 40, 3, 1'b1, 1'b1);
        check("mr_valid", wif.wr_valid, 0);
        check("mr_idle", idle, 1);
        check("mr_oob", oob_count, 0);
        check("mr_full", full, 0);
        w0 = writes;
        for (int i = 0; i < 20; i++) idle_step(1'b1);
        check("mr_no_stale", writes - w0, 0);

        // Random traffic with shifting memory availability.
        bias = 6;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) bias = $urandom_range(0, 8);
            step(($urandom % 4) != 0, $urandom_range(0, 255), $urandom_range(0, 127),
                 $urandom_range(0, 7), ($urandom_range(0, 7) < bias), 1'b0);
        end
        drain();

        // Full-screen sweep.
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        w0 = writes;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                step(1'b1, xx, yy, (xx + yy) % 8, 1'b1, 1'b0);
        drain();
        check("sweep_writes", writes - w0, 19200);
        check("sweep_no_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_write_queue.md
# pixel_write_queue

Downstream stage of the black/colour screen-sweep pixel generator. Accepts its `plot`/`x`/`y`/`color` pixel stream, discards off-screen coordinates, buffers in-range pixels in a FIFO, and converts each to a linear framebuffer write (`addr = y*160 + x`) on a valid/ready write port toward the 160x120x3 video memory. It decouples the generator, which has no backpressure, from a memory port that may stall.

## Interface
- `X_MAX`, default 160: screen width in pixels.
- `Y_MAX`, default 120: screen height in pixels.
- `DEPTH`, default 16: FIFO entries, power of two.
- `ADDR_W`, default 15: framebuffer address width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `plot` in 1: a pixel is present this cycle.
- `x` in 8: pixel column.
- `y` in 7: pixel row.
- `color` in 3: pixel colour.
- `full` out 1: FIFO occupancy equals `DEPTH`.
- `overflow` out 1: sticky; an in-range pixel was lost because the queue was full.
- `oob_count` out 8: saturating count of discarded off-screen pixels.
- `wr_valid` out 1: write request to memory.
- `wr_ready` in 1: memory accepts the write this cycle.
- `wr_addr` out `ADDR_W`: linear framebuffer address.
- `wr_data` out 3: colour to write.
- `idle` out 1: FIFO empty and `wr_valid` low.

## Operation
- In-range check: `x < X_MAX` and `y < Y_MAX`. A `plot` that fails the check is never queued, and `oob_count` increments, saturating at 255.
- Push: an in-range `plot` is written to the FIFO if occupancy < `DEPTH`, or if a pop occurs in the same cycle.
- A pixel that cannot be pushed is dropped and sets `overflow`. `overflow` clears only on reset.
- Pop: the FIFO head moves into the output register when the register is empty (`!wr_valid`) or is draining this cycle (`wr_valid && wr_ready`).
- The address is computed on pop: `wr_addr = (y<<7) + (y<<5) + x`, zero-extended to `ADDR_W`. Maximum value is 19199, with no overflow at 15 bits.
- Output register holds `wr_valid`/`wr_addr`/`wr_data` stable while `wr_valid && !wr_ready`.
- The handshake completes on any cycle with `wr_valid && wr_ready`. Pixel order is preserved strictly.
- Total capacity is `DEPTH` + 1: the FIFO plus the output register.
- Empty FIFO with the output register draining: `wr_valid` drops the next cycle. There is no bypass path around the FIFO.
- `wr_ready` is ignored while `wr_valid` is low.

## Timing
- Reset values: `full`=0, `overflow`=0, `oob_count`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `idle`=1. FIFO pointers and count are also 0.
- Reset applied mid-operation discards all queued and in-flight pixels. Outputs take their reset values the cycle after `reset` is sampled high. A `plot` in a reset cycle is ignored.
- Latency: an in-range `plot` in cycle c, with the queue empty, gives `wr_valid` in cycle c+2 carrying that pixel.
- Throughput: one write per cycle while `wr_ready` stays high.
- `full` is registered and reflects occupancy after the current edge.
- Push and pop in the same cycle while full: the push is accepted, occupancy is unchanged, `full` stays 1, and `overflow` stays 0.
- Pointers wrap modulo `DEPTH`. Occupancy is tracked with a separate counter of `$clog2(DEPTH)+1` bits.

## Structure
- Shared package `video_pkg` holds:
  - constants `X_MAX`=160, `Y_MAX`=120, `FB_ADDR_W`=15, and colour constants `BLACK`=3'b000, `WHITE`=3'b111;
  - `pixel_t` struct `{x[7:0], y[6:0], color[2:0]}`.
  This package is shared with the pixel generator and the VGA adapter.
- Sub-module `pixel_fifo`: a synchronous FIFO of `pixel_t` with push/pop/count/full/empty ports. The top level contains the range check, counters, address arithmetic and output register.

## Test plan
- Single pixel: `x`=5, `y`=3, `color`=3'b101 with `wr_ready`=1. Require `wr_valid` in cycle c+2 with `wr_addr`=485 and `wr_data`=5, then `idle`=1 one cycle later.
- Boundaries:
  - (159,119) gives `wr_addr`=19199;
  - (160,0) and (0,120) are dropped, giving `oob_count`=2 with no write;
  - 300 off-screen plots give `oob_count`=255.
- Backpressure: `wr_ready`=0 and 18 consecutive in-range plots. Require `full`=1 after the 17th and `overflow`=1 after the 18th. After releasing `wr_ready`, require exactly 17 writes, in order, one per cycle.
- Full with simultaneous pop: hold the queue full, then drive `wr_ready`=1 and `plot`=1 continuously. Require `full` to stay 1, `overflow`=0, and no pixels lost.
- Reset mid-burst: assert `reset` with 10 pixels queued. Require `wr_valid`=0, `idle`=1 and counters at 0 the next cycle, and no stale write afterwards.
- Full-screen sweep: 19200 row-major plots with `wr_ready`=1. Require 19200 writes with addresses 0..19199 in sequence and `overflow`=0.
